// File: rtl/if_id_ctrl.sv
// IF/ID sequencing controller: chooses load/loop/stall/flush for the IF/ID register each cycle,
// drives fetch hold/redirect and decoder issue strobes, and tracks halt and redirect bubbles.
module if_id_ctrl #(
    parameter int unsigned REDIRECT_BUBBLES = 2,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_i1v,
    input  logic             id_i2v,
    input  logic [1:0]       be_ready,
    input  logic             redirect,
    input  logic [15:0]      redirect_pc,
    input  logic             halt_dec,
    input  logic             resume,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             ifid_loop,
    output logic             fetch_hold,
    output logic             fetch_redirect,
    output logic [15:0]      fetch_pc,
    output logic             dec_fire1,
    output logic             dec_fire2,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] loop_cnt
);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StRedir = 2'b01,
        StHalt  = 2'b10
    } state_e;

    localparam logic [3:0] BubInit = 4'(REDIRECT_BUBBLES - 1);

    state_e     state_q;
    logic [3:0] bub_q;

    assign state_o = state_q;

    always_comb begin
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        ifid_loop  = 1'b0;
        fetch_hold = 1'b0;
        dec_fire1  = 1'b0;
        dec_fire2  = 1'b0;
        if (reset || redirect) begin
            ifid_flush = 1'b1;
        end else begin
            unique case (state_q)
                StHalt: begin
                    ifid_stall = 1'b1;
                    fetch_hold = 1'b1;
                end
                StRedir: ifid_flush = 1'b1;
                default: begin
                    if (id_i1v || id_i2v) begin
                        if (be_ready == 2'd0) begin
                            ifid_stall = 1'b1;
                            fetch_hold = 1'b1;
                        end else if (id_i1v && id_i2v) begin
                            // be_ready[1] covers both 2 and 3; with one slot free, I2 loops back
                            dec_fire1  = 1'b1;
                            dec_fire2  = be_ready[1];
                            ifid_loop  = ~be_ready[1];
                            fetch_hold = ~be_ready[1];
                        end else begin
                            dec_fire1 = id_i1v;
                            dec_fire2 = id_i2v;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StRun;
            bub_q          <= 4'd0;
            fetch_redirect <= 1'b0;
            fetch_pc       <= 16'h0000;
            stall_cnt      <= '0;
            loop_cnt       <= '0;
        end else begin
            fetch_redirect <= redirect;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                state_q  <= StRedir;
                bub_q    <= BubInit;
            end else begin
                unique case (state_q)
                    StHalt: begin
                        if (resume) state_q <= StRun;
                    end
                    StRedir: begin
                        if (bub_q == 4'd0) state_q <= StRun;
                        else               bub_q   <= bub_q - 4'd1;
                    end
                    default: begin
                        state_q <= (halt_dec && (dec_fire1 || dec_fire2)) ? StHalt : StRun;
                    end
                endcase
            end
            if (ifid_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_loop && (loop_cnt != '1))   loop_cnt  <= loop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed plus randomized bench for if_id_ctrl against a slot-counting reference model.
module tb_if_id_ctrl;

    localparam int B     = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, id_i1v, id_i2v, redirect, halt_dec, resume;
    logic [1:0]    be_ready;
    logic [15:0]   redirect_pc;
    logic          ifid_stall, ifid_flush, ifid_loop, fetch_hold, fetch_redirect;
    logic          dec_fire1, dec_fire2;
    logic [15:0]   fetch_pc;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt, loop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 run, 1 redirect bubbles, 2 halted
    int          m_state, m_rem, m_sc, m_lc;
    logic        m_fr;
    logic [15:0] m_pc;
    logic        e_stall, e_flush, e_loop, e_hold, e_f1, e_f2;

    if_id_ctrl #(.REDIRECT_BUBBLES(B), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_i1v(id_i1v), .id_i2v(id_i2v), .be_ready(be_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt_dec(halt_dec), .resume(resume),
        .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .ifid_loop(ifid_loop),
        .fetch_hold(fetch_hold), .fetch_redirect(fetch_redirect), .fetch_pc(fetch_pc),
        .dec_fire1(dec_fire1), .dec_fire2(dec_fire2), .state_o(state_o),
        .stall_cnt(stall_cnt), .loop_cnt(loop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_comb();
        int nv, r, issued;
        {e_stall, e_flush, e_loop, e_hold, e_f1, e_f2} = '0;
        nv = int'(id_i1v) + int'(id_i2v);
        r  = (be_ready > 2) ? 2 : int'(be_ready);
        issued = (nv < r) ? nv : r;
        if (reset || redirect || m_state == 1) e_flush = 1'b1;
        else if (m_state == 2) begin
            e_stall = 1'b1;
            e_hold  = 1'b1;
        end else if (nv > 0 && r == 0) begin
            e_stall = 1'b1;
            e_hold  = 1'b1;
        end else if (nv == 2) begin
            e_f1   = 1'b1;
            e_f2   = (issued == 2);
            e_loop = (nv - issued) > 0;
            e_hold = e_loop;
        end else begin
            e_f1 = id_i1v;
            e_f2 = id_i2v;
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_state = 0; m_rem = 0; m_fr = 1'b0; m_pc = '0; m_sc = 0; m_lc = 0;
        end else begin
            if (e_stall) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
            if (e_loop)  m_lc = (m_lc < CMAX) ? m_lc + 1 : CMAX;
            m_fr = redirect;
            if (redirect) begin
                m_pc = redirect_pc; m_state = 1; m_rem = B;
            end else if (m_state == 2) begin
                if (resume) m_state = 0;
            end else if (m_state == 1) begin
                m_rem--;
                if (m_rem == 0) m_state = 0;
            end else if (halt_dec && (e_f1 || e_f2)) begin
                m_state = 2;
            end
        end
    endtask

    // Compare mid-cycle, then advance one edge and the model alongside it
    task automatic step();
        @(negedge clk);
        model_comb();
        chk("ifid_stall", 32'(ifid_stall), 32'(e_stall));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_flush));
        chk("ifid_loop", 32'(ifid_loop), 32'(e_loop));
        chk("fetch_hold", 32'(fetch_hold), 32'(e_hold));
        chk("dec_fire1", 32'(dec_fire1), 32'(e_f1));
        chk("dec_fire2", 32'(dec_fire2), 32'(e_f2));
        chk("fetch_redirect", 32'(fetch_redirect), 32'(m_fr));
        chk("fetch_pc", 32'(fetch_pc), 32'(m_pc));
        chk("state_o", 32'(state_o), 32'(m_state));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
        chk("loop_cnt", 32'(loop_cnt), 32'(m_lc));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic i1, input logic i2, input logic [1:0] be);
        id_i1v = i1; id_i2v = i2; be_ready = be;
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234; halt_dec = 1'b0; resume = 1'b0;
        drive(1'b1, 1'b1, 2'd2);
        @(posedge clk);
        model_edge();
        #1;
        step();
        chk("reset_flush", 32'(ifid_flush), 32'd1);
        chk("reset_fire1", 32'(dec_fire1), 32'd0);
        step();
        reset = 1'b0; redirect = 1'b0;
        drive(1'b0, 1'b0, 2'd0);
        step();
        chk("post_reset_state", 32'(state_o), 32'd0);
        chk("post_reset_cnt", 32'(stall_cnt) + 32'(loop_cnt), 32'd0);

        // One backend slot: I2 loops back three times, then both issue
        drive(1'b1, 1'b1, 2'd1);
        repeat (3) step();
        drive(1'b1, 1'b1, 2'd2);
        step();
        chk("loop_cnt_3", 32'(loop_cnt), 32'd3);

        drive(1'b1, 1'b1, 2'd0);
        repeat (5) step();
        chk("stall_cnt_5", 32'(stall_cnt), 32'd5);

        // Redirect, then a second redirect inside the bubble window
        drive(1'b1, 1'b0, 2'd3);
        redirect = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        chk("redir_pulse", 32'(fetch_redirect), 32'd1);
        chk("redir_pc", 32'(fetch_pc), 32'h0040);
        step();
        redirect = 1'b1; redirect_pc = 16'h0080;
        step();
        redirect = 1'b0;
        chk("redir2_pc", 32'(fetch_pc), 32'h0080);
        repeat (B) step();
        chk("redir_done", 32'(state_o), 32'd0);

        // Halt on an issued slot, stay stalled, then resume+redirect together
        halt_dec = 1'b1;
        step();
        halt_dec = 1'b0;
        chk("halt_entry", 32'(state_o), 32'd2);
        repeat (4) step();
        resume = 1'b1; redirect = 1'b1; redirect_pc = 16'h00c0;
        step();
        resume = 1'b0; redirect = 1'b0;
        chk("resume_vs_redirect", 32'(state_o), 32'd1);
        repeat (3) step();

        // Random traffic, including counter saturation and in-cycle resets
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = 16'($urandom);
            halt_dec    = ($urandom_range(0, 5) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            reset       = ($urandom_range(0, 199) == 0);
            step();
            if (dec_fire2 && id_i1v) chk("in_order", 32'(dec_fire1), 32'd1);
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_ctrl.md
Name: if_id_ctrl

Overview:
- Sequencing controller for the IF/ID pipeline register.
- Each cycle it decides whether IF/ID loads a fresh fetch pair, reloads the leftover instruction from the decoder (loop), holds (stall) or clears (flush).
- Also generates fetch-side hold/redirect and decoder issue strobes, and tracks redirect bubbles, halt and performance counts.
- Sits between FetchStage, IF/ID register, Decoder and the execute-stage redirect source.

Parameters:
- REDIRECT_BUBBLES, 2, cycles flush stays asserted after a redirect (range 1..15).
- CNT_W, 16, width of saturating performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_i1v  in  1  IF/ID slot-1 valid (I1V_out)
- id_i2v  in  1  IF/ID slot-2 valid (I2V_out)
- be_ready  in  2  backend slots free this cycle (0,1,2; 3 treated as 2)
- redirect  in  1  mispredict/redirect request from execute
- redirect_pc  in  16  target PC
- halt_dec  in  1  decoder saw a halt instruction in an issued slot
- resume  in  1  external resume from halt
- ifid_stall  out  1  to IF/ID stall
- ifid_flush  out  1  to IF/ID flush
- ifid_loop  out  1  to IF/ID loop
- fetch_hold  out  1  freeze fetch PC/outputs
- fetch_redirect  out  1  one-cycle pulse: load fetch PC
- fetch_pc  out  16  PC for fetch_redirect (registered)
- dec_fire1  out  1  slot 1 issued this cycle
- dec_fire2  out  1  slot 2 issued this cycle
- state_o  out  2  00 RUN, 01 REDIR, 10 HALT
- stall_cnt  out  CNT_W  cycles with ifid_stall=1, saturating
- loop_cnt  out  CNT_W  cycles with ifid_loop=1, saturating

Behaviour:
- Reset (synchronous): state=RUN, bubble counter=0, fetch_pc=0, fetch_redirect=0, counters=0. Combinational outputs with reset=1: ifid_flush=1, all others 0.
- Priority within a cycle: reset > redirect > HALT > REDIR > be_ready issue logic.
- RUN issue logic (combinational, same cycle), with nv = id_i1v+id_i2v and r = min(be_ready,2):
  - nv=0: stall=0, loop=0, hold=0, fires=0.
  - r=0 and nv>0: stall=1, hold=1, fires=0.
  - nv=2, r=2: fire1=fire2=1, stall=0, loop=0, hold=0.
  - nv=2, r=1: fire1=1, fire2=0, loop=1, hold=1 (decoder shifts I2 into slot 1 via loop path).
  - nv=1, r>=1: fire the valid slot only (I2-only case fires fire2), loop=0, hold=0.
  - In-order rule: fire2 is never 1 while id_i1v=1 and fire1=0.
- Redirect (any state, reset=0):
  - Same cycle: ifid_flush=1, fires=0, loop=0, stall=0.
  - Next edge: fetch_redirect=1 for exactly one cycle; fetch_pc=redirect_pc; state=REDIR; bubble counter=REDIRECT_BUBBLES-1.
- REDIR:
  - ifid_flush=1, fires=0, hold=0.
  - Counter decrements each cycle; at 0, next state=RUN.
  - A new redirect in REDIR restarts the sequence with the new PC; the latest redirect wins.
- HALT entry: halt_dec=1 with a fire in RUN. That cycle's issue completes; next state=HALT.
- HALT:
  - ifid_stall=1, fetch_hold=1, fires=0.
  - resume=1 returns to RUN next cycle.
  - Redirect overrides HALT (goes to REDIR).
  - resume and redirect in the same cycle: redirect wins.
- Counters: increment at the edge when the respective output is 1 (including HALT stalls). Hold at all-ones. Cleared only by reset.
- ifid_stall, ifid_flush and ifid_loop are mutually exclusive except during reset. With reset=1, only ifid_flush=1.

Test Plan:
- Reset with redirect=1 and be_ready=2 -> ifid_flush=1, all other outputs 0; after release state_o=00, counters 0.
- id_i1v=id_i2v=1, be_ready=1 for 3 cycles, then 2 -> loop=1 and hold=1 for 3 cycles, then fire1=fire2=1; loop_cnt=3.
- be_ready=0 with nv=2 for 5 cycles -> stall=1, hold=1; stall_cnt=5; fires stay 0.
- redirect=1, redirect_pc=16'h0040, REDIRECT_BUBBLES=2:
  - Same cycle flush=1.
  - Next cycle fetch_redirect=1, fetch_pc=0040.
  - Flush=1 for 2 REDIR cycles, then RUN.
- Second redirect (pc=16'h0080) during REDIR -> new fetch_redirect pulse with pc=0080, bubble count restarted.
- halt_dec with fire1 -> HALT; 4 cycles stall=1; resume and redirect in same cycle -> REDIR, not RUN.
